// File: rtl/pdua_control.sv
// Instruction sequencer for the PDUA datapath: fetch, decode, execute and
// operand-fetch states driving the register bank, ALU and memory interface.
module pdua_control #(
    parameter int ADDR_WIDTH = 3,
    parameter int OPC_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OPC_WIDTH-1:0]  out_IR,
    input  logic                  C,
    input  logic                  N,
    input  logic                  P,
    input  logic                  Z,
    input  logic                  hold,
    output logic                  enaf,
    output logic [2:0]            selop,
    output logic [1:0]            shamt,
    output logic                  bank_wr_en,
    output logic [ADDR_WIDTH-1:0] BusB_addr,
    output logic [ADDR_WIDTH-1:0] BusC_addr,
    output logic                  sclr,
    output logic                  ir_en,
    output logic                  mar_en,
    output logic                  mdr_en,
    output logic                  mdr_alu_n,
    output logic                  wr_rdn,
    output logic                  halted
);

    localparam logic [ADDR_WIDTH-1:0] REG_PC  = '0;
    localparam logic [ADDR_WIDTH-1:0] REG_A   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] REG_ACC = '1;

    localparam logic [OPC_WIDTH-1:0] OP_NOP  = OPC_WIDTH'(5'b00000);
    localparam logic [OPC_WIDTH-1:0] OP_MOVI = OPC_WIDTH'(5'b00001);
    localparam logic [OPC_WIDTH-1:0] OP_MVAA = OPC_WIDTH'(5'b00010);
    localparam logic [OPC_WIDTH-1:0] OP_MVAC = OPC_WIDTH'(5'b00011);
    localparam logic [OPC_WIDTH-1:0] OP_ADD  = OPC_WIDTH'(5'b00100);
    localparam logic [OPC_WIDTH-1:0] OP_AND  = OPC_WIDTH'(5'b00101);
    localparam logic [OPC_WIDTH-1:0] OP_NOT  = OPC_WIDTH'(5'b00110);
    localparam logic [OPC_WIDTH-1:0] OP_SHL  = OPC_WIDTH'(5'b00111);
    localparam logic [OPC_WIDTH-1:0] OP_JMP  = OPC_WIDTH'(5'b01000);
    localparam logic [OPC_WIDTH-1:0] OP_JZ   = OPC_WIDTH'(5'b01001);
    localparam logic [OPC_WIDTH-1:0] OP_JN   = OPC_WIDTH'(5'b01010);
    localparam logic [OPC_WIDTH-1:0] OP_HALT = OPC_WIDTH'(5'b11111);

    typedef enum logic [3:0] {
        S_INIT, S_F0, S_F1, S_F2, S_DEC, S_EX, S_OP0, S_OP1, S_OP2, S_SKIP, S_HALT
    } state_t;

    state_t state_q, state_d;

    // Carry and parity flags are not consulted by this instruction set.
    logic unused_flags;
    assign unused_flags = C ^ P;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_INIT;
        else     state_q <= state_d;
    end

    // Next-state decode and Moore outputs; hold gates the enables afterwards.
    always_comb begin
        state_d    = state_q;
        enaf       = 1'b0;
        selop      = 3'b000;
        shamt      = 2'b00;
        bank_wr_en = 1'b0;
        BusB_addr  = REG_PC;
        BusC_addr  = REG_PC;
        sclr       = 1'b0;
        ir_en      = 1'b0;
        mar_en     = 1'b0;
        mdr_en     = 1'b0;
        mdr_alu_n  = 1'b0;
        wr_rdn     = 1'b0;
        halted     = 1'b0;

        case (state_q)
            S_INIT: begin
                sclr    = 1'b1;
                state_d = S_F0;
            end
            // Instruction and operand address phases share outputs.
            S_F0, S_OP0: begin
                mar_en    = 1'b1;
                BusB_addr = REG_PC;
                selop     = 3'b000;
                state_d   = (state_q == S_F0) ? S_F1 : S_OP1;
            end
            S_F1, S_OP1: begin
                mdr_en     = 1'b1;
                BusB_addr  = REG_PC;
                selop      = 3'b110;
                bank_wr_en = 1'b1;
                BusC_addr  = REG_PC;
                state_d    = (state_q == S_F1) ? S_F2 : S_OP2;
            end
            S_F2: begin
                ir_en   = 1'b1;
                state_d = S_DEC;
            end
            S_DEC: begin
                if (out_IR == OP_MOVI || out_IR == OP_JMP)   state_d = S_OP0;
                else if (out_IR == OP_JZ)                    state_d = Z ? S_OP0 : S_SKIP;
                else if (out_IR == OP_JN)                    state_d = N ? S_OP0 : S_SKIP;
                else if (out_IR >= OP_MVAA && out_IR <= OP_SHL) state_d = S_EX;
                else if (out_IR == OP_HALT)                  state_d = S_HALT;
                else                                         state_d = S_F0;
            end
            S_EX: begin
                bank_wr_en = 1'b1;
                state_d    = S_F0;
                case (out_IR)
                    OP_MVAA: begin BusB_addr = REG_A;   BusC_addr = REG_ACC; end
                    OP_MVAC: begin BusB_addr = REG_ACC; BusC_addr = REG_A;   end
                    OP_ADD:  begin BusB_addr = REG_A;   BusC_addr = REG_ACC; selop = 3'b001; enaf = 1'b1; end
                    OP_AND:  begin BusB_addr = REG_A;   BusC_addr = REG_ACC; selop = 3'b010; enaf = 1'b1; end
                    OP_NOT:  begin BusB_addr = REG_ACC; BusC_addr = REG_ACC; selop = 3'b100; enaf = 1'b1; end
                    OP_SHL:  begin
                        BusB_addr = REG_ACC; BusC_addr = REG_ACC;
                        selop = 3'b111; shamt = 2'b01; enaf = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_OP2: begin
                bank_wr_en = 1'b1;
                mdr_alu_n  = 1'b1;
                BusC_addr  = (out_IR == OP_MOVI) ? REG_ACC : REG_PC;
                state_d    = S_F0;
            end
            S_SKIP: begin
                BusB_addr  = REG_PC;
                selop      = 3'b110;
                bank_wr_en = 1'b1;
                BusC_addr  = REG_PC;
                state_d    = S_F0;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_INIT;
        endcase

        if (hold && state_q != S_INIT && state_q != S_HALT) begin
            state_d    = state_q;
            enaf       = 1'b0;
            bank_wr_en = 1'b0;
            ir_en      = 1'b0;
            mar_en     = 1'b0;
            mdr_en     = 1'b0;
            wr_rdn     = 1'b0;
            sclr       = 1'b0;
        end
    end

    logic unused_nop;
    assign unused_nop = (OP_NOP == '0);

endmodule
